// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the 9-bit-instruction fetch path: sequencer states,
// default widths and the opcodes the decoder uses to raise branch/halt.
package fetch_sequencer_pkg;

  localparam int DEF_PC_W  = 10;
  localparam int DEF_CNT_W = 16;
  localparam int INSTR_W   = 9;

  // Opcode field is the top three bits of an instruction word.
  localparam int OPC_W = 3;
  localparam logic [OPC_W-1:0] OP_BRANCH = 3'b101;
  localparam logic [OPC_W-1:0] OP_JUMP   = 3'b110;
  localparam logic [OPC_W-1:0] OP_HALT   = 3'b111;

  // Flush/drain down-counter width; holds loads up to 7.
  localparam int SEQ_CTR_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/status bundle between the execute-stage control (master) and the
// fetch sequencer (slave).
//
// Handshake: there is no backpressure on this bundle. start_req is a
// one-cycle pulse honoured only while the sequencer is idle or done and
// dropped otherwise; branch_taken/branch_target and halt_in are qualified
// per cycle by their own level; all status outputs are registered levels.
interface fetch_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             start_req;
  logic             stall;
  logic             branch_taken;
  logic [PC_W-1:0]  branch_target;
  logic             halt_in;
  logic [PC_W-1:0]  pc;
  logic             fetch_valid;
  logic             flush;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start_req, stall, branch_taken, branch_target, halt_in,
    input  pc, fetch_valid, flush, busy, done, cycle_count
  );

  modport slave (
    input  start_req, stall, branch_taken, branch_target, halt_in,
    output pc, fetch_valid, flush, busy, done, cycle_count
  );
endinterface

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count enabled cycles, sticking at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, starts on request, redirects on taken
// branches with a fixed bubble count, drains after halt, and counts busy cycles.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W      = DEF_PC_W,
  parameter int FLUSH_CYC = 2,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  fetch_sequencer_if.slave    bus,
  output seq_state_t          state_dbg
);

  localparam logic [SEQ_CTR_W-1:0] FLUSH_LD = SEQ_CTR_W'(FLUSH_CYC - 1);
  localparam logic [SEQ_CTR_W-1:0] DRAIN_LD = SEQ_CTR_W'(DRAIN_CYC - 1);

  seq_state_t            state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic                  fv_q, fv_d;
  logic                  flush_q, flush_d;
  logic [SEQ_CTR_W-1:0]  ctr_q, ctr_d;
  logic                  start_clr;
  logic                  busy;
  logic                  done_lvl;
  logic [CNT_W-1:0]      count;

  // State, PC, fetch/flush flags and bubble/drain counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      fv_q    <= 1'b0;
      flush_q <= 1'b0;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fv_q    <= fv_d;
      flush_q <= flush_d;
      ctr_q   <= ctr_d;
    end
  end

  // Next-state logic; halt beats branch beats stall beats advance.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fv_d      = fv_q;
    flush_d   = 1'b0;
    ctr_d     = ctr_q;
    start_clr = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        fv_d = 1'b0;
        if (bus.start_req) begin
          state_d   = RUN;
          pc_d      = '0;
          fv_d      = 1'b1;
          ctr_d     = '0;
          start_clr = 1'b1;
        end
      end
      RUN: begin
        if (bus.halt_in) begin
          state_d = DRAIN;
          flush_d = 1'b1;
          fv_d    = 1'b0;
          ctr_d   = DRAIN_LD;
        end else if (bus.branch_taken) begin
          state_d = FLUSH;
          pc_d    = bus.branch_target;
          flush_d = 1'b1;
          fv_d    = 1'b0;
          ctr_d   = FLUSH_LD;
        end else if (!bus.stall) begin
          pc_d = pc_q + PC_W'(1);
          fv_d = 1'b1;
        end
      end
      FLUSH: begin
        if (bus.halt_in) begin
          state_d = DRAIN;
          flush_d = 1'b1;
          fv_d    = 1'b0;
          ctr_d   = DRAIN_LD;
        end else if (bus.branch_taken) begin
          pc_d    = bus.branch_target;
          flush_d = 1'b1;
          fv_d    = 1'b0;
          ctr_d   = FLUSH_LD;
        end else if (ctr_q == '0) begin
          // Last bubble done: the held target is fetched next cycle.
          state_d = RUN;
          fv_d    = 1'b1;
        end else begin
          ctr_d   = ctr_q - SEQ_CTR_W'(1);
          flush_d = 1'b1;
          fv_d    = 1'b0;
        end
      end
      DRAIN: begin
        fv_d = 1'b0;
        if (ctr_q == '0) begin
          state_d = DONE;
        end else begin
          ctr_d = ctr_q - SEQ_CTR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        fv_d    = 1'b0;
      end
    endcase
  end

  // Status decode from the state register only (no input-to-output path).
  always_comb begin
    busy     = (state_q == RUN) || (state_q == FLUSH) || (state_q == DRAIN);
    done_lvl = (state_q == DONE);
  end

  sat_counter #(.W(CNT_W)) u_cycle_ctr (
    .clk   (clk),
    .reset (reset),
    .en    (busy),
    .clr   (start_clr),
    .count (count)
  );

  assign bus.pc          = pc_q;
  assign bus.fetch_valid = fv_q;
  assign bus.flush       = flush_q;
  assign bus.busy        = busy;
  assign bus.done        = done_lvl;
  assign bus.cycle_count = count;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (default widths, and a narrow
// PC_W=4/CNT_W=4 build with one bubble and one drain cycle) driven by the
// same stimulus and compared every cycle against a cycle-level model.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(10), .CNT_W(16)) bus0 ();
  fetch_sequencer_if #(.PC_W(4),  .CNT_W(4))  bus1 ();
  seq_state_t dbg0, dbg1;

  fetch_sequencer #(.PC_W(10), .FLUSH_CYC(2), .DRAIN_CYC(3), .CNT_W(16)) dut0 (
    .clk(clk), .reset(rst), .bus(bus0), .state_dbg(dbg0)
  );
  fetch_sequencer #(.PC_W(4), .FLUSH_CYC(1), .DRAIN_CYC(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(rst), .bus(bus1), .state_dbg(dbg1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Per-instance configuration seen by the model.
  int pcw[2] = '{10, 4};
  int fcy[2] = '{2, 1};
  int dcy[2] = '{3, 1};
  int cnw[2] = '{16, 4};

  // Model: expected outputs plus remaining bubble / drain cycles.
  int m_pc[2], m_count[2], m_bub[2], m_drain[2];
  bit m_fv[2], m_flush[2], m_busy[2], m_done[2];

  // Inputs currently applied.
  bit cur_st, cur_sl, cur_br, cur_hl;
  int cur_tg;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_count[k] = 0; m_bub[k] = 0; m_drain[k] = 0;
      m_fv[k] = 0; m_flush[k] = 0; m_busy[k] = 0; m_done[k] = 0;
    end
  endfunction

  function automatic void model_step(int k);
    int maxc = (1 << cnw[k]) - 1;
    int span = 1 << pcw[k];
    if (m_busy[k] && m_count[k] < maxc) m_count[k]++;
    if (!m_busy[k]) begin
      m_fv[k] = 0; m_flush[k] = 0;
      if (cur_st) begin
        m_busy[k] = 1; m_done[k] = 0; m_pc[k] = 0; m_fv[k] = 1;
        m_count[k] = 0; m_bub[k] = 0; m_drain[k] = 0;
      end
    end else if (m_drain[k] > 0) begin
      m_flush[k] = 0; m_fv[k] = 0;
      m_drain[k]--;
      if (m_drain[k] == 0) begin m_busy[k] = 0; m_done[k] = 1; end
    end else if (cur_hl) begin
      m_drain[k] = dcy[k]; m_bub[k] = 0; m_flush[k] = 1; m_fv[k] = 0;
    end else if (cur_br) begin
      m_pc[k] = cur_tg % span; m_bub[k] = fcy[k]; m_flush[k] = 1; m_fv[k] = 0;
    end else if (m_bub[k] > 0) begin
      m_bub[k]--;
      m_flush[k] = (m_bub[k] > 0);
      m_fv[k] = (m_bub[k] == 0);
    end else if (cur_sl) begin
      m_flush[k] = 0;
    end else begin
      m_pc[k] = (m_pc[k] + 1) % span; m_fv[k] = 1; m_flush[k] = 0;
    end
  endfunction

  // Packed views: {pc, fetch_valid, flush, busy, done, cycle_count}.
  function automatic logic [35:0] get_exp(int k);
    return {16'(m_pc[k]), m_fv[k], m_flush[k], m_busy[k], m_done[k], 16'(m_count[k])};
  endfunction

  function automatic logic [35:0] get_obs(int k);
    if (k == 0)
      return {16'(bus0.pc), bus0.fetch_valid, bus0.flush, bus0.busy, bus0.done, 16'(bus0.cycle_count)};
    return {16'(bus1.pc), bus1.fetch_valid, bus1.flush, bus1.busy, bus1.done, 16'(bus1.cycle_count)};
  endfunction

  task automatic drive(input bit st, input bit sl, input bit br, input int tg, input bit hl);
    cur_st = st; cur_sl = sl; cur_br = br; cur_tg = tg; cur_hl = hl;
    bus0.start_req = st; bus0.stall = sl; bus0.branch_taken = br;
    bus0.branch_target = 10'(tg); bus0.halt_in = hl;
    bus1.start_req = st; bus1.stall = sl; bus1.branch_taken = br;
    bus1.branch_target = 4'(tg); bus1.halt_in = hl;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) for (int k = 0; k < 2; k++) model_step(k);
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_run();
    drive(1, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic wait_pc(input int target, input string name);
    int n = 0;
    while (bus0.pc !== 10'(target) && n < 40) begin step(); n++; end
    checks++;
    if (bus0.pc !== 10'(target)) begin
      errors++;
      $display("FAIL %s reach pc: got %0h expected %0h", name, bus0.pc, target);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (get_obs(k) !== get_exp(k)) begin
        errors++;
        $display("FAIL reset dut%0d got %h expected %h", k, get_obs(k), get_exp(k));
      end
    end
    checks++;
    if (dbg0 !== IDLE || dbg1 !== IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d/%0d expected %0d", dbg0, dbg1, IDLE);
    end
    // Non-start inputs must be ignored while idle.
    drive(0, 1, 1, 'h33, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (get_obs(k) !== get_exp(k)) begin
          errors++;
          $display("FAIL idle_ignore dut%0d cyc%0d got %h expected %h", k, cyc, get_obs(k), get_exp(k));
        end
      end
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_start();
    apply_reset();
    step();
    start_run();
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (get_obs(k) !== get_exp(k)) begin
          errors++;
          $display("FAIL start dut%0d cyc%0d got %h expected %h", k, cyc, get_obs(k), get_exp(k));
        end
      end
      checks++;
      if (bus0.pc !== 10'(c) || bus0.fetch_valid !== 1'b1 || bus0.busy !== 1'b1) begin
        errors++;
        $display("FAIL start_seq pc got %0h fv %0b busy %0b expected pc %0h fv 1 busy 1",
                 bus0.pc, bus0.fetch_valid, bus0.busy, c);
      end
      step();
    end
  endtask

  task automatic test_branch();
    logic [9:0] e_pc[4] = '{10'h40, 10'h40, 10'h40, 10'h41};
    logic       e_fl[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       e_fv[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    apply_reset();
    start_run();
    wait_pc(5, "branch");
    drive(0, 0, 1, 'h40, 0);
    step();
    drive(0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (get_obs(k) !== get_exp(k)) begin
          errors++;
          $display("FAIL branch dut%0d cyc%0d got %h expected %h", k, cyc, get_obs(k), get_exp(k));
        end
      end
      checks++;
      if (bus0.pc !== e_pc[c] || bus0.flush !== e_fl[c] || bus0.fetch_valid !== e_fv[c]) begin
        errors++;
        $display("FAIL branch_seq step%0d got pc %0h fl %0b fv %0b expected pc %0h fl %0b fv %0b",
                 c, bus0.pc, bus0.flush, bus0.fetch_valid, e_pc[c], e_fl[c], e_fv[c]);
      end
      step();
    end
  endtask

  task automatic test_stall();
    apply_reset();
    start_run();
    wait_pc(7, "stall");
    drive(0, 1, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (get_obs(k) !== get_exp(k)) begin
          errors++;
          $display("FAIL stall dut%0d cyc%0d got %h expected %h", k, cyc, get_obs(k), get_exp(k));
        end
      end
      checks++;
      if (bus0.pc !== 10'd7 || bus0.fetch_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold got pc %0h fv %0b expected pc 7 fv 1", bus0.pc, bus0.fetch_valid);
      end
    end
    drive(0, 1, 1, 'h123, 0);
    step();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (bus0.pc !== 10'h123 || bus0.flush !== 1'b1) begin
      errors++;
      $display("FAIL stall_branch got pc %0h fl %0b expected pc 123 fl 1", bus0.pc, bus0.flush);
    end
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (get_obs(k) !== get_exp(k)) begin
          errors++;
          $display("FAIL stall_branch dut%0d cyc%0d got %h expected %h", k, cyc, get_obs(k), get_exp(k));
        end
      end
      step();
    end
  endtask

  task automatic test_halt();
    apply_reset();
    start_run();
    wait_pc(9, "halt");
    drive(0, 0, 1, 'h55, 1);
    step();
    drive(0, 1, 1, 'h66, 0);
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (get_obs(k) !== get_exp(k)) begin
          errors++;
          $display("FAIL halt dut%0d cyc%0d got %h expected %h", k, cyc, get_obs(k), get_exp(k));
        end
      end
      checks++;
      if (bus0.pc !== 10'd9 || bus0.done !== (c >= 3) || bus0.busy !== (c < 3) ||
          bus0.flush !== (c == 0) || bus0.fetch_valid !== 1'b0) begin
        errors++;
        $display("FAIL halt_seq step%0d got pc %0h done %0b busy %0b fl %0b fv %0b",
                 c, bus0.pc, bus0.done, bus0.busy, bus0.flush, bus0.fetch_valid);
      end
      step();
    end
    start_run();
    checks++;
    if (bus0.pc !== 10'd0 || bus0.cycle_count !== 16'd0 || bus0.done !== 1'b0 || bus0.fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL restart got pc %0h cnt %0d done %0b fv %0b expected pc 0 cnt 0 done 0 fv 1",
               bus0.pc, bus0.cycle_count, bus0.done, bus0.fetch_valid);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (get_obs(k) !== get_exp(k)) begin
        errors++;
        $display("FAIL restart dut%0d got %h expected %h", k, get_obs(k), get_exp(k));
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    start_run();
    for (int c = 0; c < 20; c++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (get_obs(k) !== get_exp(k)) begin
          errors++;
          $display("FAIL wrap dut%0d cyc%0d got %h expected %h", k, cyc, get_obs(k), get_exp(k));
        end
      end
      checks++;
      if (bus1.pc !== 4'(c % 16) || bus1.cycle_count !== 4'((c > 15) ? 15 : c)) begin
        errors++;
        $display("FAIL wrap_narrow step%0d got pc %0d cnt %0d expected pc %0d cnt %0d",
                 c, bus1.pc, bus1.cycle_count, c % 16, (c > 15) ? 15 : c);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    start_run();
    // start_req while busy must not restart.
    drive(1, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (get_obs(k) !== get_exp(k)) begin
          errors++;
          $display("FAIL busy_start dut%0d cyc%0d got %h expected %h", k, cyc, get_obs(k), get_exp(k));
        end
      end
    end
    checks++;
    if (bus0.pc !== 10'd3) begin
      errors++;
      $display("FAIL busy_start_pc got %0h expected 3", bus0.pc);
    end
    // Reset in the middle of a flush.
    drive(0, 0, 1, 'h2a, 0);
    step();
    drive(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (get_obs(k) !== get_exp(k)) begin
        errors++;
        $display("FAIL reset_in_flush dut%0d got %h expected %h", k, get_obs(k), get_exp(k));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    // Reset in the middle of a drain.
    start_run();
    step();
    drive(0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (bus0.busy !== 1'b1 || bus0.flush !== 1'b1) begin
      errors++;
      $display("FAIL drain_entry got busy %0b fl %0b expected busy 1 fl 1", bus0.busy, bus0.flush);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (get_obs(k) !== get_exp(k)) begin
        errors++;
        $display("FAIL reset_in_drain dut%0d got %h expected %h", k, get_obs(k), get_exp(k));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (get_obs(k) !== get_exp(k)) begin
        errors++;
        $display("FAIL post_reset dut%0d got %h expected %h", k, get_obs(k), get_exp(k));
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 3) == 0,
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) == 0,
            int'($urandom_range(0, 1023)),
            $urandom_range(0, 39) == 0);
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (get_obs(k) !== get_exp(k)) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d got %h expected %h", k, cyc, get_obs(k), get_exp(k));
        end
      end
    end
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_start();
    test_branch();
    test_stall();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at cyc %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
